instr_fetch: RTL

Instruction fetch front end for the single-cycle RISC-V core: the initiator side of the instruction memory port. It owns the PC and drives address/enable into the synchronous-read instruction memory, which returns data one cycle after the enabled edge. Returned instructions are buffered in a small FIFO and handed to decode over a valid/ready handshake. It supports branch/jump redirect with flush of in-flight and buffered words, and flags misaligned or out-of-range fetch addresses.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 54 +++++
 rtl/instr_fetch.sv | 95 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared core definitions: datapath widths, fetch defaults, the fetch buffer
// entry and the instruction-memory address legality rule.
package cpu_pkg;

    localparam int              XLEN               = 32;
    localparam int              INSTR_W            = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT   = 32'h0000_0000;
    localparam int              IMEM_WORDS_DEFAULT = 1024;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Word-aligned and inside the memory; compared at XLEN+1 bits so a
    // memory spanning the full address space still has a representable limit.
    function automatic logic fetch_addr_ok(input logic [XLEN-1:0] addr,
                                           input int unsigned     words);
        logic [XLEN:0] limit;
        limit = {1'b0, words} << 2;
        return (addr[1:0] == 2'b00) && ({1'b0, addr} < limit);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Shift-register fetch buffer: entry 0 is always the head, so the head
// outputs come straight from flops with no read mux.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  fetch_entry_t     din,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             head_valid,
    output fetch_entry_t     head
);

    fetch_entry_t     mem [DEPTH];
    logic             do_pop;
    logic [CNT_W-1:0] wr_idx;

    assign do_pop     = pop && (count != '0);
    assign wr_idx     = count - CNT_W'(do_pop);
    assign head_valid = (count != '0);
    assign head       = mem[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(push) - CNT_W'(do_pop);
            if (do_pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    mem[i] <= mem[i+1];
                end
            end
            // Written after the shift so a simultaneous push lands in the
            // slot the shift just vacated.
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (CNT_W'(i) == wr_idx)) begin
                    mem[i] <= din;
                end
            end
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: owns the PC, issues reads to the synchronous
// instruction memory and buffers returned words for decode.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              IMEM_WORDS = IMEM_WORDS_DEFAULT,
    parameter int              DEPTH      = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               InstrMemEn,
    output logic               InstrMemWr,
    output logic [XLEN-1:0]    Addr,
    input  logic [INSTR_W-1:0] instr,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [XLEN-1:0]    out_pc,
    output logic               fault
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pend_pc;
    logic             pending;
    logic [CNT_W-1:0] count;
    logic             pop;
    logic             room;
    logic             pc_ok;
    logic             try_issue;
    logic             issue;
    logic             push;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    assign pop = out_valid && out_ready;

    // The in-flight word already owns a slot, so it counts against capacity.
    assign room = (32'(count) + 32'(pending) - 32'(pop)) < 32'(DEPTH);

    assign pc_ok     = fetch_addr_ok(pc, IMEM_WORDS);
    assign try_issue = !rst && !redirect_valid && !fault && room;
    assign issue     = try_issue && pc_ok;
    assign push      = pending && !redirect_valid;

    assign InstrMemEn = issue;
    assign InstrMemWr = 1'b0;
    assign Addr       = pc;

    assign push_entry = '{pc: pend_pc, instr: instr};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .din        (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .count      (count),
        .head_valid (out_valid),
        .head       (head)
    );

    assign out_pc    = head.pc;
    assign out_instr = head.instr;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            pend_pc <= '0;
            pending <= 1'b0;
            fault   <= 1'b0;
        end else if (redirect_valid) begin
            pc      <= redirect_pc;
            pending <= 1'b0;
            fault   <= !fetch_addr_ok(redirect_pc, IMEM_WORDS);
        end else begin
            pending <= issue;
            if (issue) begin
                pc      <= pc + XLEN'(4);
                pend_pc <= pc;
            end
            if (try_issue && !pc_ok) begin
                fault <= 1'b1;
            end
        end
    end

endmodule
